// File: rtl/sb_io_out_arbiter_if.sv
// sb_io_out_arbiter_if
//   Bundles the requester handshake and the SB_IO pin bus of sb_io_out_arbiter.
//   master : requester side (drives req_valid/req_data, observes everything else)
//   slave  : arbiter side  (drives req_ready, pin_d_out, pin_oe, grant_id, busy)
//
//   req_valid  NUM_REQ         request i wants the bus, held until req_ready[i]
//   req_data   NUM_REQ*DATA_W  data of requester i at [i*DATA_W +: DATA_W]
//   req_ready  NUM_REQ         one-hot acceptance
//   pin_d_out  DATA_W          registered data to SB_IO D_OUT_0
//   pin_oe     1               registered output enable to SB_IO
//   grant_id   GID_W           index of the most recent grant
//   busy       1               arbiter not idle
interface sb_io_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int GID_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         pin_d_out;
  logic                      pin_oe;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, pin_d_out, pin_oe, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, pin_d_out, pin_oe, grant_id, busy
  );
endinterface

// File: rtl/sb_io_out_arbiter.sv
// sb_io_out_arbiter
//   Round-robin arbiter that shares one registered SB_IO output bus between
//   NUM_REQ requesters. A grant drives the winner's data with the enable high
//   for HOLD_CYCLES, then keeps the bus released (enable and data low) for
//   TURN_CYCLES before the next arbitration cycle.
//
//   clock    rising-edge clock
//   reset_n  synchronous reset, active low
//   bus      sb_io_out_arbiter_if.slave (handshake in, pin bus and status out)
module sb_io_out_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sb_io_out_arbiter_if.slave    bus
);

  localparam int GID_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN
  } state_e;

  state_e             state_q,     state_d;
  logic [DATA_W-1:0]  pin_d_out_q, pin_d_out_d;
  logic               pin_oe_q,    pin_oe_d;
  logic [GID_W-1:0]   grant_id_q,  grant_id_d;
  logic [GID_W-1:0]   ptr_q,       ptr_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic               win_found;
  logic [GID_W-1:0]   win_idx;
  logic [GID_W-1:0]   cand;

  // Round-robin search: the first valid requester at or above the pointer,
  // wrapping at NUM_REQ. Only the first hit is kept.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Acceptance is only offered in IDLE and is forced low while reset is held,
  // so no transfer can be signalled during reset.
  assign bus.req_ready = (reset_n && (state_q == S_IDLE) && win_found)
                         ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d     = state_q;
    pin_d_out_d = pin_d_out_q;
    pin_oe_d    = pin_oe_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // In IDLE a found winner is always ready, so a winner means a transfer.
        if (win_found) begin
          state_d     = S_DRIVE;
          pin_d_out_d = bus.req_data[win_idx*DATA_W +: DATA_W];
          pin_oe_d    = 1'b1;
          grant_id_d  = win_idx;
          ptr_d       = GID_W'((int'(win_idx) + 1) % NUM_REQ);
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          // Data is cleared together with the enable so the pad never sees
          // stale data while released.
          pin_oe_d    = 1'b0;
          pin_d_out_d = '0;
          if (TURN_CYCLES > 0) begin
            state_d = S_TURN;
            cnt_d   = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronous reset aborts any grant in flight and rewinds the pointer.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pin_d_out_q <= '0;
      pin_oe_q    <= 1'b0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pin_d_out_q <= pin_d_out_d;
      pin_oe_q    <= pin_oe_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pin_d_out = pin_d_out_q;
  assign bus.pin_oe    = pin_oe_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sb_io_out_arbiter.sv
// tb_sb_io_out_arbiter
//   Self-checking bench for sb_io_out_arbiter (NUM_REQ=4, DATA_W=8,
//   HOLD_CYCLES=2, TURN_CYCLES=1). Expected grants are queued as stimulus is
//   applied and popped by a monitor when pin_oe rises.
module tb_sb_io_out_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  sb_io_out_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  sb_io_out_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(2), .TURN_CYCLES(1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  grant_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until some req_ready bit is high, reporting the cycles waited.
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: bus invariants each cycle, grant contents on each pin_oe rise,
  // enable length on each fall.
  bit     mon_en  = 1'b0;
  logic   prev_oe = 1'b0;
  int     hold_n  = 0;
  grant_t cur     = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("oe_low_data_zero", 32'(bus.pin_oe ? 8'h00 : bus.pin_d_out), 32'd0);
      check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.pin_oe && !prev_oe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(bus.grant_id), 32'hFFFF);
        end else begin
          cur = exp_q.pop_front();
          check("grant_id", 32'(bus.grant_id), 32'(cur.id));
          check("grant_data", 32'(bus.pin_d_out), 32'(cur.data));
        end
        hold_n = 1;
      end else if (bus.pin_oe) begin
        hold_n++;
        check("data_stable", 32'(bus.pin_d_out), 32'(cur.data));
      end
      if (!bus.pin_oe && prev_oe) check("hold_len", 32'(hold_n), 32'd2);
      prev_oe = bus.pin_oe;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset held for 3 cycles with every requester valid.
    reset_n       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    check("rst_ready_pre", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_oe", 32'(bus.pin_oe), 32'd0);
      check("rst_dout", 32'(bus.pin_d_out), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_gid", 32'(bus.grant_id), 32'd0);
    end
    mon_en = 1'b1;

    // All requesters held valid: round robin 0,1,2,3,0, one grant per 4 cycles.
    reset_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_q.push_back('{id: 2'(g % 4), data: 8'(8'h10 + (g % 4))});
    end
    for (int g = 0; g < 5; g++) begin
      wait_ready(n);
      check("rr_ready", 32'(bus.req_ready), 32'(1 << (g % 4)));
      if (g > 0) check("rr_period", 32'(n), 32'd3);
      tick();
      if (g == 4) bus.req_valid = '0;
    end
    wait_idle();

    // Single request from requester 2.
    bus.req_data[23:16] = 8'hA5;
    bus.req_valid       = 4'b0100;
    #1;
    check("single_ready_c0", 32'(bus.req_ready), 32'h4);
    exp_q.push_back('{id: 2'd2, data: 8'hA5});
    tick();
    bus.req_valid = '0;
    check("single_oe_c1", 32'(bus.pin_oe), 32'd1);
    check("single_dout_c1", 32'(bus.pin_d_out), 32'hA5);
    check("single_busy_c1", 32'(bus.busy), 32'd1);
    #1;
    check("single_ready_c1", 32'(bus.req_ready), 32'd0);
    tick();
    check("single_oe_c2", 32'(bus.pin_oe), 32'd1);
    check("single_dout_c2", 32'(bus.pin_d_out), 32'hA5);
    tick();
    check("single_oe_c3", 32'(bus.pin_oe), 32'd0);
    check("single_dout_c3", 32'(bus.pin_d_out), 32'd0);
    check("single_busy_c3", 32'(bus.busy), 32'd1);
    tick();
    check("single_busy_c4", 32'(bus.busy), 32'd0);
    check("single_gid_c4", 32'(bus.grant_id), 32'd2);

    // Pointer now 3: requesters 3 and 0 valid -> 3 first, then wrap to 0.
    bus.req_data[31:24] = 8'hC3;
    bus.req_data[7:0]   = 8'h3C;
    bus.req_valid       = 4'b1001;
    exp_q.push_back('{id: 2'd3, data: 8'hC3});
    exp_q.push_back('{id: 2'd0, data: 8'h3C});
    wait_ready(n);
    check("wrap_first", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0001;
    wait_ready(n);
    check("wrap_second", 32'(bus.req_ready), 32'h1);
    check("wrap_period", 32'(n), 32'd3);
    tick();
    bus.req_valid = '0;
    wait_idle();

    // Reset during the second DRIVE cycle of a grant to requester 1.
    bus.req_data[15:8] = 8'h55;
    bus.req_valid      = 4'b0010;
    exp_q.push_back('{id: 2'd1, data: 8'h55});
    wait_ready(n);
    check("abort_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    check("abort_oe_c1", 32'(bus.pin_oe), 32'd1);
    tick();
    check("abort_oe_c2", 32'(bus.pin_oe), 32'd1);
    reset_n       = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    check("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
    tick();
    check("abort_oe", 32'(bus.pin_oe), 32'd0);
    check("abort_dout", 32'(bus.pin_d_out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_gid", 32'(bus.grant_id), 32'd0);
    reset_n = 1'b1;
    exp_q.push_back('{id: 2'd0, data: 8'h3C});
    exp_q.push_back('{id: 2'd1, data: 8'h55});
    #1;
    check("post_rst_first", 32'(bus.req_ready), 32'h1);
    tick();
    wait_ready(n);
    check("post_rst_second", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    wait_idle();

    // Requester 1 pulses valid only while another grant is in DRIVE/TURN.
    bus.req_data[31:24] = 8'h77;
    bus.req_valid       = 4'b1000;
    exp_q.push_back('{id: 2'd3, data: 8'h77});
    wait_ready(n);
    check("pulse_ready_owner", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0010;
    #1;
    check("pulse_ready_drive1", 32'(bus.req_ready), 32'd0);
    tick();
    check("pulse_ready_drive2", 32'(bus.req_ready), 32'd0);
    tick();
    bus.req_valid = '0;
    check("pulse_busy_turn", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pulse_ready_after", 32'(bus.req_ready), 32'd0);
      check("pulse_gid_after", 32'(bus.grant_id), 32'd3);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
